// File: rtl/adbg_or1k_halt_ctrl.sv
// adbg_or1k_halt_ctrl: per-core halt request/acknowledge handshake with sticky timeout flags,
// plus breakpoint edge pulses with optional cross-triggering to all cores.
module adbg_or1k_halt_ctrl #(
   parameter int NB_CORES  = 4,
   parameter int TIMEOUT_W = 8
) (
   input  logic                cpu_clk_i,
   input  logic                cpu_rstn_i,
   input  logic [NB_CORES-1:0] stall_i,
   input  logic [NB_CORES-1:0] core_halted_i,
   input  logic [NB_CORES-1:0] core_bp_i,
   input  logic                xtrig_en_i,
   input  logic                err_clr_i,
   output logic [NB_CORES-1:0] halt_req_o,
   output logic [NB_CORES-1:0] bp_o,
   output logic [NB_CORES-1:0] halted_o,
   output logic                all_halted_o,
   output logic [NB_CORES-1:0] timeout_o
);
   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] REQ    = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;
   localparam logic [1:0] RESUME = 2'd3;
   localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

   logic [NB_CORES-1:0] bp_q;
   logic [NB_CORES-1:0] bp_edge;

   genvar n;
   generate
      for (n = 0; n < NB_CORES; n++) begin : g_core
         logic [1:0]           state;
         logic [1:0]           state_nxt;
         logic [TIMEOUT_W-1:0] cnt;
         logic [TIMEOUT_W-1:0] cnt_nxt;
         logic                 waiting;
         logic                 sat;
         logic                 fresh;
         logic                 req_q;
         logic                 halted_q;
         logic                 tmo_q;
         always_comb begin
            state_nxt = state;
            case (state)
               RUN:     if (stall_i[n]) state_nxt = REQ;
               REQ:     if (core_halted_i[n]) state_nxt = HALTED;
                        else if (!stall_i[n]) state_nxt = RUN;
               HALTED:  if (!stall_i[n]) state_nxt = RESUME;
               default: if (stall_i[n]) state_nxt = REQ;
                        else if (!core_halted_i[n]) state_nxt = RUN;
            endcase
         end
         assign waiting = (state_nxt == REQ) || (state_nxt == RESUME);
         assign sat     = (cnt == CNT_MAX);
         assign cnt_nxt = (state_nxt != state || !waiting) ? '0 : sat ? cnt : cnt + 1'b1;
         // A fresh arrival at all-ones beats err_clr_i; an already saturated counter re-arms the flag a cycle later.
         assign fresh   = !sat && (cnt_nxt == CNT_MAX);
         always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
            if (!cpu_rstn_i) begin
               state    <= RUN;
               cnt      <= '0;
               req_q    <= 1'b0;
               halted_q <= 1'b0;
               tmo_q    <= 1'b0;
            end else begin
               state    <= state_nxt;
               cnt      <= cnt_nxt;
               req_q    <= (state_nxt == REQ) || (state_nxt == HALTED);
               halted_q <= (state_nxt == HALTED);
               tmo_q    <= fresh | ((tmo_q | sat) & ~err_clr_i);
            end
         end
         assign halt_req_o[n] = req_q;
         assign halted_o[n]   = halted_q;
         assign timeout_o[n]  = tmo_q;
      end
   endgenerate

   assign bp_edge = core_bp_i & ~bp_q;

   always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
      if (!cpu_rstn_i) begin
         bp_q <= '0;
         bp_o <= '0;
      end else begin
         bp_q <= core_bp_i;
         bp_o <= xtrig_en_i ? {NB_CORES{|bp_edge}} : bp_edge;
      end
   end

   assign all_halted_o = &halted_o;
endmodule

// File: tb/tb_adbg_or1k_halt_ctrl.sv
// tb_adbg_or1k_halt_ctrl: vector table, handshake corner sequences and randomized traffic
// checked against a behavioural handshake model.
module tb_adbg_or1k_halt_ctrl;
   localparam int NB  = 4;
   localparam int TW  = 4;
   localparam int LIM = (1 << TW) - 1;
   localparam int S_RUN = 0, S_REQ = 1, S_HLT = 2, S_RES = 3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [NB-1:0] stall = '0, hi = '0, cbp = '0;
   logic xtrig = 1'b0, clr = 1'b0;
   logic [NB-1:0] hreq, bpo, hlt, tmo;
   logic allh;

   adbg_or1k_halt_ctrl #(.NB_CORES(NB), .TIMEOUT_W(TW)) dut (
      .cpu_clk_i(clk), .cpu_rstn_i(rstn), .stall_i(stall), .core_halted_i(hi),
      .core_bp_i(cbp), .xtrig_en_i(xtrig), .err_clr_i(clr), .halt_req_o(hreq),
      .bp_o(bpo), .halted_o(hlt), .all_halted_o(allh), .timeout_o(tmo));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int m_st[NB];
   int m_wait[NB];
   logic [NB-1:0] m_tmo, m_bpq, m_bp, m_hreq, m_hlt;

   typedef struct {
      logic [3:0] s, h, b;
      logic       x, c;
      int         rep;
      logic [3:0] ehr, ehl, ebp;
      logic       eall;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t v(logic [3:0] s, logic [3:0] h, logic [3:0] b, logic x, logic c, int rep,
                              logic [3:0] ehr, logic [3:0] ehl, logic [3:0] ebp, logic eall);
      vec_t r;
      r.s = s; r.h = h; r.b = b; r.x = x; r.c = c; r.rep = rep;
      r.ehr = ehr; r.ehl = ehl; r.ebp = ebp; r.eall = eall;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         m_st[i] = S_RUN;
         m_wait[i] = 0;
      end
      m_tmo = '0; m_bpq = '0; m_bp = '0; m_hreq = '0; m_hlt = '0;
   endtask

   function automatic int next_state(int st, logic s, logic h);
      case (st)
         S_RUN:   return s ? S_REQ : S_RUN;
         S_REQ:   return h ? S_HLT : (s ? S_REQ : S_RUN);
         S_HLT:   return s ? S_HLT : S_RES;
         default: return s ? S_REQ : (h ? S_RES : S_RUN);
      endcase
   endfunction

   // Wait time is kept as an unbounded cycle count; the flag fires when it first reaches LIM.
   task automatic model_edge();
      logic [NB-1:0] e;
      for (int i = 0; i < NB; i++) begin
         int ns, wb, wn;
         ns = next_state(m_st[i], stall[i], hi[i]);
         wb = m_wait[i];
         wn = (ns != m_st[i]) ? 0 : (ns == S_REQ || ns == S_RES) ? wb + 1 : 0;
         m_tmo[i]  = (wn == LIM) ? 1'b1 : clr ? 1'b0 : (m_tmo[i] | (wb >= LIM));
         m_st[i]   = ns;
         m_wait[i] = wn;
         m_hreq[i] = (ns == S_REQ) || (ns == S_HLT);
         m_hlt[i]  = (ns == S_HLT);
      end
      e = cbp & ~m_bpq;
      m_bpq = cbp;
      m_bp = xtrig ? {NB{|e}} : e;
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, "_halt_req"}, 32'(hreq), 32'(m_hreq));
      chk({tag, "_halted"},   32'(hlt),  32'(m_hlt));
      chk({tag, "_bp"},       32'(bpo),  32'(m_bp));
      chk({tag, "_all"},      32'(allh), 32'(&m_hlt));
      chk({tag, "_timeout"},  32'(tmo),  32'(m_tmo));
   endtask

   task automatic step(input logic [3:0] s, input logic [3:0] h, input logic [3:0] b,
                       input logic x, input logic c, input string tag);
      stall = s; hi = h; cbp = b; xtrig = x; clr = c;
      @(posedge clk);
      model_edge();
      #1;
      cmp_model(tag);
   endtask

   initial begin
      // core 0 handshake
      tbl.push_back(v(4'h1, 4'h0, 4'h0, 0, 0, 3, 4'h1, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 4'h1, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h1, 4'h0, 0, 0, 2, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));
      // all cores
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 0, 0, 1, 4'hF, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'hF, 4'hF, 4'h0, 0, 0, 2, 4'hF, 4'hF, 4'h0, 1));
      tbl.push_back(v(4'h0, 4'hF, 4'h0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));
      // breakpoints, local then cross-triggered
      tbl.push_back(v(4'h0, 4'h0, 4'h4, 0, 0, 1, 4'h0, 4'h0, 4'h4, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h4, 0, 0, 9, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h4, 1, 0, 1, 4'h0, 4'h0, 4'hF, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h4, 1, 0, 9, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 1, 0, 1, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'hA, 0, 0, 1, 4'h0, 4'h0, 4'hA, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h5, 1, 0, 1, 4'h0, 4'h0, 4'hF, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));
      // abort after a 2-cycle stall
      tbl.push_back(v(4'h1, 4'h0, 4'h0, 0, 0, 2, 4'h1, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h0, 4'h0, 4'h0, 0));
      // re-stall during RESUME
      tbl.push_back(v(4'h1, 4'h0, 4'h0, 0, 0, 1, 4'h1, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 4'h1, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h1, 4'h0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 4'h1, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_halt_req", 32'(hreq), 0);
      chk("reset_halted",   32'(hlt),  0);
      chk("reset_bp",       32'(bpo),  0);
      chk("reset_all",      32'(allh), 0);
      chk("reset_timeout",  32'(tmo),  0);
      @(negedge clk);
      rstn = 1'b1;

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].rep; r++) begin
            step(tbl[i].s, tbl[i].h, tbl[i].b, tbl[i].x, tbl[i].c, $sformatf("tbl%0d_model", i));
            chk($sformatf("tbl%0d_halt_req", i), 32'(hreq), 32'(tbl[i].ehr));
            chk($sformatf("tbl%0d_halted", i),   32'(hlt),  32'(tbl[i].ehl));
            chk($sformatf("tbl%0d_bp", i),       32'(bpo),  32'(tbl[i].ebp));
            chk($sformatf("tbl%0d_all", i),      32'(allh), 32'(tbl[i].eall));
            chk($sformatf("tbl%0d_timeout", i),  32'(tmo),  0);
         end
      end

      // core 1 never acks: flag appears on the 15th edge after REQ entry
      for (int k = 0; k <= LIM; k++) begin
         step(4'h2, 4'h0, 4'h0, 0, 0, "to_wait");
         chk($sformatf("to_rise_k%0d", k), 32'(tmo), (k == LIM) ? 32'h2 : 32'h0);
      end
      repeat (3) begin
         step(4'h2, 4'h0, 4'h0, 0, 0, "to_hold");
         chk("to_sticky", 32'(tmo), 32'h2);
      end
      step(4'h2, 4'h0, 4'h0, 0, 1, "to_clr");
      chk("to_cleared", 32'(tmo), 32'h0);
      step(4'h2, 4'h0, 4'h0, 0, 0, "to_reset");
      chk("to_rearmed", 32'(tmo), 32'h2);
      // core 2 reaches all-ones on the same edge as a clear: its set wins, core 1 is cleared
      for (int k = 0; k < LIM; k++) step(4'h6, 4'h0, 4'h0, 0, 0, "to2_wait");
      step(4'h6, 4'h0, 4'h0, 0, 1, "to2_clr");
      chk("to_set_beats_clr", 32'(tmo), 32'h4);
      step(4'h6, 4'h0, 4'h0, 0, 0, "to2_after");
      chk("to_both", 32'(tmo), 32'h6);
      step(4'h6, 4'h6, 4'h0, 0, 0, "to_ack");
      chk("to_ack_halted", 32'(hlt), 32'h6);
      chk("to_ack_timeout", 32'(tmo), 32'h6);

      // asynchronous reset while halted with timeouts pending
      #3;
      rstn = 1'b0;
      stall = '0; hi = '0; cbp = '0; clr = 1'b0;
      #1;
      chk("areset_halt_req", 32'(hreq), 0);
      chk("areset_halted",   32'(hlt),  0);
      chk("areset_timeout",  32'(tmo),  0);
      chk("areset_bp",       32'(bpo),  0);
      chk("areset_all",      32'(allh), 0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      step(4'h0, 4'h0, 4'h0, 0, 0, "post_reset");
      step(4'h1, 4'h0, 4'h0, 0, 0, "post_reset_req");
      chk("post_reset_req", 32'(hreq), 32'h1);
      step(4'h0, 4'h0, 4'h0, 0, 0, "post_reset_abort");

      // randomized traffic; acks follow requests with random latency, sometimes never
      begin
         logic [3:0] s, h, b;
         logic x, c;
         s = '0; h = '0; b = '0; x = 1'b0;
         for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < NB; i++) begin
               if ($urandom_range(0, 29) == 0) s[i] = ~s[i];
               if (m_hreq[i] && $urandom_range(0, 7) == 0) h[i] = ($urandom_range(0, 4) != 0);
               if (!m_hreq[i] && $urandom_range(0, 3) == 0) h[i] = 1'b0;
               if ($urandom_range(0, 3) == 0) b[i] = ~b[i];
            end
            if ($urandom_range(0, 49) == 0) x = ~x;
            c = ($urandom_range(0, 19) == 0);
            step(s, h, b, x, c, "rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
